// File: rtl/plc_pkg.sv
// Shared types and default sizing for the multi-entry protected line checker.
package plc_pkg;

  localparam int PLC_ADDR_WIDTH    = 8;
  localparam int PLC_WAY_WIDTH     = 4;
  localparam int PLC_DATA_SIZE     = 64;
  localparam int PLC_LIST_DEPTH    = 8;
  localparam int PLC_CHECK_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REPORT = 2'd2
  } plc_state_e;

  // Watch-list entry layout at default sizing; the watch list declares the
  // width-parameterised equivalent with identical field order.
  typedef struct packed {
    logic                      valid;
    logic [PLC_ADDR_WIDTH-1:0] addr;
    logic [PLC_WAY_WIDTH-1:0]  way;
    logic [PLC_DATA_SIZE-1:0]  golden;
  } plc_entry_t;

endpackage

// File: rtl/plc_multi_checker_if.sv
// Upstream request / array port / status bundle of plc_multi_checker.
interface plc_multi_checker_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int WAY_WIDTH  = 4,
  parameter int DATA_SIZE  = 64
);
  logic                  add_to_list;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [WAY_WIDTH-1:0]  way_in;
  logic                  read_enable_in;
  logic                  alt_mx_sel_in;
  logic                  write_enable;
  logic [DATA_SIZE-1:0]  data;
  logic                  plc_error_found;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic [WAY_WIDTH-1:0]  way_out;
  logic                  read_enable_out;
  logic                  alt_mx_sel_out;
  logic                  list_full;
  logic                  check_busy;
  logic [ADDR_WIDTH-1:0] error_addr;
  logic [WAY_WIDTH-1:0]  error_way;

  modport master (
    output add_to_list, addr_in, way_in, read_enable_in, alt_mx_sel_in,
           write_enable, data,
    input  plc_error_found, addr_out, way_out, read_enable_out,
           alt_mx_sel_out, list_full, check_busy, error_addr, error_way
  );

  modport slave (
    input  add_to_list, addr_in, way_in, read_enable_in, alt_mx_sel_in,
           write_enable, data,
    output plc_error_found, addr_out, way_out, read_enable_out,
           alt_mx_sel_out, list_full, check_busy, error_addr, error_way
  );
endinterface

// File: rtl/plc_watch_list.sv
// Watch-list storage: entries, (addr,way) CAM match, lowest-free and
// lowest-pending priority encoders, per-entry pending bits.
module plc_watch_list #(
  parameter int ADDR_WIDTH = 8,
  parameter int WAY_WIDTH  = 4,
  parameter int DATA_SIZE  = 64,
  parameter int LIST_DEPTH = 8,
  localparam int IDX_W     = $clog2(LIST_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [WAY_WIDTH-1:0]  way_in,
  input  logic [DATA_SIZE-1:0]  data,
  input  logic                  upd_en,     // refresh golden of hit entry
  input  logic                  alloc_en,   // allocate at free_idx
  input  logic                  watch_en,   // watch write: set pending on hit
  input  logic                  clr_en,     // check done for clr_idx
  input  logic [IDX_W-1:0]      clr_idx,
  input  logic                  clr_keep,   // entry re-hit while under check
  input  logic [IDX_W-1:0]      chk_idx,
  output logic                  hit,
  output logic [IDX_W-1:0]      hit_idx,
  output logic [IDX_W-1:0]      free_idx,
  output logic                  list_full,
  output logic                  pend_any,
  output logic [IDX_W-1:0]      pend_idx,
  output logic [ADDR_WIDTH-1:0] pend_addr,
  output logic [WAY_WIDTH-1:0]  pend_way,
  output logic [ADDR_WIDTH-1:0] chk_addr,
  output logic [WAY_WIDTH-1:0]  chk_way,
  output logic [DATA_SIZE-1:0]  chk_golden
);

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WAY_WIDTH-1:0]  way;
    logic [DATA_SIZE-1:0]  golden;
  } entry_t;

  entry_t                ent_q [LIST_DEPTH];
  entry_t                ent_d [LIST_DEPTH];
  logic [LIST_DEPTH-1:0] pend_q, pend_d;
  logic [LIST_DEPTH-1:0] match, valid_v;

  for (genvar g = 0; g < LIST_DEPTH; g++) begin : g_cam
    assign valid_v[g] = ent_q[g].valid;
    assign match[g]   = ent_q[g].valid && (ent_q[g].addr == addr_in) &&
                        (ent_q[g].way == way_in);
  end

  assign list_full  = &valid_v;
  assign hit        = |match;
  assign pend_any   = |pend_q;
  assign pend_addr  = ent_q[pend_idx].addr;
  assign pend_way   = ent_q[pend_idx].way;
  assign chk_addr   = ent_q[chk_idx].addr;
  assign chk_way    = ent_q[chk_idx].way;
  assign chk_golden = ent_q[chk_idx].golden;

  // Lowest-index priority encoders for hit, free slot and pending check.
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    pend_idx = '0;
    for (int i = LIST_DEPTH - 1; i >= 0; i--) begin
      if (match[i])    hit_idx  = IDX_W'(i);
      if (!valid_v[i]) free_idx = IDX_W'(i);
      if (pend_q[i])   pend_idx = IDX_W'(i);
    end
  end

  // Entry updates and pending set/clear; a re-hit during a check survives the clear.
  always_comb begin
    for (int i = 0; i < LIST_DEPTH; i++) begin
      ent_d[i]  = ent_q[i];
      pend_d[i] = pend_q[i] | (watch_en && hit && (hit_idx == IDX_W'(i)));
      if (upd_en && (hit_idx == IDX_W'(i)))
        ent_d[i].golden = data;
      if (alloc_en && (free_idx == IDX_W'(i)))
        ent_d[i] = '{valid: 1'b1, addr: addr_in, way: way_in, golden: data};
      if (clr_en && (clr_idx == IDX_W'(i)))
        pend_d[i] = clr_keep | (watch_en && hit && (hit_idx == IDX_W'(i)));
    end
  end

  // Entry and pending state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LIST_DEPTH; i++) ent_q[i] <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < LIST_DEPTH; i++) ent_q[i] <= ent_d[i];
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/plc_multi_checker.sv
// Multi-entry protected line checker: registers watched lines, schedules a
// check-read after any write to one, injects it on an idle array cycle and
// reports golden mismatches. Array request is otherwise passed through,
// registered. Optional PLC_ERR_COUNT_EN adds a saturating 8-bit err_count.
module plc_multi_checker
  import plc_pkg::*;
#(
  parameter int ADDR_WIDTH    = PLC_ADDR_WIDTH,
  parameter int WAY_WIDTH     = PLC_WAY_WIDTH,
  parameter int DATA_SIZE     = PLC_DATA_SIZE,
  parameter int LIST_DEPTH    = PLC_LIST_DEPTH,
  parameter int CHECK_LATENCY = PLC_CHECK_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  plc_multi_checker_if.slave bus
`ifdef PLC_ERR_COUNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int IDX_W = $clog2(LIST_DEPTH);
  localparam int CNT_W = $clog2(CHECK_LATENCY + 1);

  plc_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  rehit_q, rehit_d;
  logic                  armed_q, armed_d;
  logic [ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
  logic [WAY_WIDTH-1:0]  way_out_q, way_out_d;
  logic                  rd_out_q, rd_out_d;
  logic                  alt_out_q, alt_out_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] error_addr_q, error_addr_d;
  logic [WAY_WIDTH-1:0]  error_way_q, error_way_d;

  logic                  reg_en, watch_en, upd_en, alloc_en, clr_en, inject;
  logic                  hit, list_full, pend_any;
  logic [IDX_W-1:0]      hit_idx, free_idx, pend_idx;
  logic [ADDR_WIDTH-1:0] pend_addr, chk_addr;
  logic [WAY_WIDTH-1:0]  pend_way, chk_way;
  logic [DATA_SIZE-1:0]  chk_golden;

  plc_watch_list #(
    .ADDR_WIDTH(ADDR_WIDTH), .WAY_WIDTH(WAY_WIDTH),
    .DATA_SIZE(DATA_SIZE),   .LIST_DEPTH(LIST_DEPTH)
  ) u_list (
    .clk(clk), .rst_n(rst_n),
    .addr_in(bus.addr_in), .way_in(bus.way_in), .data(bus.data),
    .upd_en(upd_en), .alloc_en(alloc_en), .watch_en(watch_en),
    .clr_en(clr_en), .clr_idx(idx_q), .clr_keep(rehit_q), .chk_idx(idx_q),
    .hit(hit), .hit_idx(hit_idx), .free_idx(free_idx), .list_full(list_full),
    .pend_any(pend_any), .pend_idx(pend_idx),
    .pend_addr(pend_addr), .pend_way(pend_way),
    .chk_addr(chk_addr), .chk_way(chk_way), .chk_golden(chk_golden)
  );

  // Arming: add_to_list arms; next plain write registers (hit refresh or allocate).
  always_comb begin
    armed_d  = armed_q;
    reg_en   = bus.write_enable && armed_q && !bus.add_to_list;
    watch_en = bus.write_enable && !armed_q;
    upd_en   = reg_en && hit;
    alloc_en = reg_en && !hit && !list_full;
    if (bus.add_to_list) armed_d = 1'b1;
    else if (reg_en)     armed_d = 1'b0;
  end

  // Check FSM: inject on idle upstream cycle, wait, sample, report.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    rehit_d      = rehit_q;
    inject       = 1'b0;
    clr_en       = 1'b0;
    err_d        = 1'b0;
    error_addr_d = error_addr_q;
    error_way_d  = error_way_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_any && !bus.read_enable_in) begin
          inject  = 1'b1;
          idx_d   = pend_idx;
          cnt_d   = '0;
          rehit_d = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (watch_en && hit && (hit_idx == idx_q)) rehit_d = 1'b1;
        if (cnt_q == CNT_W'(CHECK_LATENCY)) begin
          state_d = ST_REPORT;
          if (bus.data != chk_golden) begin
            err_d        = 1'b1;
            error_addr_d = chk_addr;
            error_way_d  = chk_way;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REPORT: begin
        clr_en  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Array port: registered passthrough, overridden by the injected check-read.
  always_comb begin
    addr_out_d = inject ? pend_addr : bus.addr_in;
    way_out_d  = inject ? pend_way  : bus.way_in;
    rd_out_d   = inject | bus.read_enable_in;
    alt_out_d  = inject | bus.alt_mx_sel_in;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      rehit_q      <= 1'b0;
      armed_q      <= 1'b0;
      addr_out_q   <= '0;
      way_out_q    <= '0;
      rd_out_q     <= 1'b0;
      alt_out_q    <= 1'b0;
      err_q        <= 1'b0;
      error_addr_q <= '0;
      error_way_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      rehit_q      <= rehit_d;
      armed_q      <= armed_d;
      addr_out_q   <= addr_out_d;
      way_out_q    <= way_out_d;
      rd_out_q     <= rd_out_d;
      alt_out_q    <= alt_out_d;
      err_q        <= err_d;
      error_addr_q <= error_addr_d;
      error_way_q  <= error_way_d;
    end
  end

  assign bus.plc_error_found = err_q;
  assign bus.addr_out        = addr_out_q;
  assign bus.way_out         = way_out_q;
  assign bus.read_enable_out = rd_out_q;
  assign bus.alt_mx_sel_out  = alt_out_q;
  assign bus.list_full       = list_full;
  assign bus.check_busy      = (state_q != ST_IDLE) || pend_any;
  assign bus.error_addr      = error_addr_q;
  assign bus.error_way       = error_way_q;

`ifdef PLC_ERR_COUNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Saturating mismatch counter, counts alongside the error pulse.
  always_comb begin
    err_count_d = err_count_q;
    if (err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_q <= '0;
    else        err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_plc_multi_checker.sv
// Directed self-checking bench for plc_multi_checker.
module tb_plc_multi_checker;
  localparam int CL = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
`ifdef PLC_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  plc_multi_checker_if #(.ADDR_WIDTH(8), .WAY_WIDTH(4), .DATA_SIZE(64)) bus ();

  plc_multi_checker #(
    .ADDR_WIDTH(8), .WAY_WIDTH(4), .DATA_SIZE(64), .LIST_DEPTH(8), .CHECK_LATENCY(CL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef PLC_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.add_to_list    = 1'b0;
    bus.addr_in        = '0;
    bus.way_in         = '0;
    bus.read_enable_in = 1'b0;
    bus.alt_mx_sel_in  = 1'b0;
    bus.write_enable   = 1'b0;
    bus.data           = '0;
  endtask

  task automatic reg_line(input logic [7:0] a, input logic [3:0] w, input logic [63:0] d);
    bus.add_to_list = 1'b1;
    tick();
    bus.add_to_list  = 1'b0;
    bus.write_enable = 1'b1;
    bus.addr_in = a; bus.way_in = w; bus.data = d;
    tick();
    bus.write_enable = 1'b0;
  endtask

  // Watch-hit write then full check sequence; off-sample cycles carry data
  // that would flip the outcome if sampled.
  task automatic run_check(input logic [7:0] a, input logic [3:0] w, input logic [63:0] golden,
                           input logic [63:0] sdata, input logic exp_err, input string tag);
    logic [63:0] noise;
    noise = exp_err ? golden : ~golden;
    bus.write_enable = 1'b1; bus.addr_in = a; bus.way_in = w;
    bus.data = 64'hDEAD_BEEF; bus.read_enable_in = 1'b0;
    tick();
    bus.write_enable = 1'b0; bus.data = noise;
    checks++; if (bus.check_busy !== 1'b1) begin failures++; $display("FAIL %s busy_pending got=%b exp=1", tag, bus.check_busy); end
    tick();
    checks++;
    if ({bus.read_enable_out, bus.alt_mx_sel_out, bus.addr_out, bus.way_out} !== {1'b1, 1'b1, a, w}) begin
      failures++; $display("FAIL %s inject got=%b%b %h/%h exp=11 %h/%h", tag, bus.read_enable_out,
                           bus.alt_mx_sel_out, bus.addr_out, bus.way_out, a, w);
    end
    for (int k = 1; k <= CL; k++) begin
      tick();
      bus.data = (k == CL) ? sdata : noise;
    end
    checks++; if (bus.read_enable_out !== 1'b0) begin failures++; $display("FAIL %s rd_after got=%b exp=0", tag, bus.read_enable_out); end
    tick();
    bus.data = noise;
    checks++; if (bus.plc_error_found !== exp_err) begin failures++; $display("FAIL %s err_pulse got=%b exp=%b", tag, bus.plc_error_found, exp_err); end
    checks++; if (bus.check_busy !== 1'b1) begin failures++; $display("FAIL %s busy_report got=%b exp=1", tag, bus.check_busy); end
    if (exp_err) begin
      checks++;
      if ({bus.error_addr, bus.error_way} !== {a, w}) begin
        failures++; $display("FAIL %s err_loc got=%h/%h exp=%h/%h", tag, bus.error_addr, bus.error_way, a, w);
      end
    end
    tick();
    checks++; if ({bus.plc_error_found, bus.check_busy} !== 2'b00) begin failures++; $display("FAIL %s after_report got=%b%b exp=00", tag, bus.plc_error_found, bus.check_busy); end
    bus.data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    bus.addr_in = 8'hFF; bus.read_enable_in = 1'b1; bus.alt_mx_sel_in = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.plc_error_found, bus.addr_out, bus.way_out, bus.read_enable_out, bus.alt_mx_sel_out,
         bus.list_full, bus.check_busy, bus.error_addr, bus.error_way} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%b%h%h%b%b%b%b%h%h exp=0", bus.plc_error_found, bus.addr_out,
                           bus.way_out, bus.read_enable_out, bus.alt_mx_sel_out, bus.list_full, bus.check_busy,
                           bus.error_addr, bus.error_way);
    end
`ifdef PLC_ERR_COUNT_EN
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
`endif
    drive_idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_register();
    reg_line(8'h12, 4'hC, 64'h0);
    checks++;
    if ({bus.addr_out, bus.way_out, bus.read_enable_out} !== {8'h12, 4'hC, 1'b0}) begin
      failures++; $display("FAIL reg_passthru got=%h/%h/%b exp=12/c/0", bus.addr_out, bus.way_out, bus.read_enable_out);
    end
    bus.addr_in = 8'h3A; bus.way_in = 4'h5; bus.read_enable_in = 1'b1; bus.alt_mx_sel_in = 1'b1;
    tick();
    checks++;
    if ({bus.addr_out, bus.way_out, bus.read_enable_out, bus.alt_mx_sel_out} !== {8'h3A, 4'h5, 1'b1, 1'b1}) begin
      failures++; $display("FAIL passthru got=%h/%h/%b%b exp=3a/5/11", bus.addr_out, bus.way_out,
                           bus.read_enable_out, bus.alt_mx_sel_out);
    end
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.check_busy, bus.plc_error_found, bus.list_full} !== 3'b000) begin
        failures++; $display("FAIL reg_no_check got=%b%b%b exp=000", bus.check_busy, bus.plc_error_found, bus.list_full);
      end
    end
    reg_line(8'h55, 4'hF, 64'h0);
  endtask

  task automatic test_check_match();
    run_check(8'h55, 4'hF, 64'h0, 64'h0, 1'b0, "match");
  endtask

  task automatic test_check_mismatch();
    run_check(8'h55, 4'hF, 64'h0, 64'h2, 1'b1, "mismatch");
`ifdef PLC_ERR_COUNT_EN
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL err_count got=%0d exp=1", err_count); end
`endif
  endtask

  task automatic test_busy_upstream();
    bus.write_enable = 1'b1; bus.addr_in = 8'h12; bus.way_in = 4'hC; bus.read_enable_in = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      bus.write_enable = 1'b0; bus.read_enable_in = 1'b1; bus.alt_mx_sel_in = 1'b0;
      bus.addr_in = 8'h80 + 8'(k); bus.way_in = 4'(k);
      tick();
      checks++;
      if ({bus.read_enable_out, bus.alt_mx_sel_out, bus.addr_out, bus.check_busy} !== {1'b1, 1'b0, 8'h80 + 8'(k), 1'b1}) begin
        failures++; $display("FAIL busy_hold%0d got=%b%b %h %b exp=10 %h 1", k, bus.read_enable_out,
                             bus.alt_mx_sel_out, bus.addr_out, bus.check_busy, 8'h80 + 8'(k));
      end
    end
    bus.read_enable_in = 1'b0; bus.addr_in = 8'h77; bus.way_in = 4'h1;
    tick();
    drive_idle();
    checks++;
    if ({bus.read_enable_out, bus.alt_mx_sel_out, bus.addr_out, bus.way_out} !== {1'b1, 1'b1, 8'h12, 4'hC}) begin
      failures++; $display("FAIL busy_inject got=%b%b %h/%h exp=11 12/c", bus.read_enable_out,
                           bus.alt_mx_sel_out, bus.addr_out, bus.way_out);
    end
    repeat (CL + 1) tick();
    checks++; if ({bus.plc_error_found, bus.check_busy} !== 2'b01) begin failures++; $display("FAIL busy_report got=%b%b exp=01", bus.plc_error_found, bus.check_busy); end
    tick();
    checks++; if (bus.check_busy !== 1'b0) begin failures++; $display("FAIL busy_done got=%b exp=0", bus.check_busy); end
  endtask

  task automatic test_list_full();
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    for (int i = 0; i < 8; i++) begin
      reg_line(8'hA0 + 8'(i), 4'(i), 64'h100 + 64'(i));
      checks++;
      if (bus.list_full !== (i == 7)) begin failures++; $display("FAIL full_after%0d got=%b exp=%b", i, bus.list_full, (i == 7)); end
    end
    reg_line(8'hB0, 4'h3, 64'h999);
    checks++; if (bus.list_full !== 1'b1) begin failures++; $display("FAIL full_ninth got=%b exp=1", bus.list_full); end
    bus.write_enable = 1'b1; bus.addr_in = 8'hB0; bus.way_in = 4'h3;
    tick();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.check_busy, bus.read_enable_out} !== 2'b00) begin
        failures++; $display("FAIL ninth_unwatched got=%b%b exp=00", bus.check_busy, bus.read_enable_out);
      end
    end
    reg_line(8'hA3, 4'h3, 64'h333);
    run_check(8'hA3, 4'h3, 64'h333, 64'h103, 1'b1, "golden_refresh");
    run_check(8'hA7, 4'h7, 64'h107, 64'h107, 1'b0, "last_entry");
  endtask

  task automatic test_back_to_back();
    int inj;
    int errs;
    inj = 0; errs = 0;
    bus.data = 64'h105;
    bus.write_enable = 1'b1; bus.addr_in = 8'hA5; bus.way_in = 4'h5;
    tick();
    bus.write_enable = 1'b0;
    tick();
    for (int c = 1; c <= 20; c++) begin
      if (bus.read_enable_out === 1'b1) inj++;
      if (bus.plc_error_found === 1'b1) errs++;
      bus.write_enable = (c == 1 || c == 2);
      tick();
    end
    checks++; if (inj !== 2) begin failures++; $display("FAIL recheck_count got=%0d exp=2", inj); end
    checks++; if (errs !== 0) begin failures++; $display("FAIL recheck_err got=%0d exp=0", errs); end
    checks++; if (bus.check_busy !== 1'b0) begin failures++; $display("FAIL recheck_idle got=%b exp=0", bus.check_busy); end
  endtask

  task automatic test_reset_mid_wait();
    bus.write_enable = 1'b1; bus.addr_in = 8'hA6; bus.way_in = 4'h6; bus.data = 64'h0;
    tick();
    bus.write_enable = 1'b0; bus.data = 64'hBAD;
    tick();
    checks++; if (bus.read_enable_out !== 1'b1) begin failures++; $display("FAIL mid_inject got=%b exp=1", bus.read_enable_out); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.plc_error_found, bus.addr_out, bus.way_out, bus.read_enable_out, bus.alt_mx_sel_out,
         bus.list_full, bus.check_busy, bus.error_addr, bus.error_way} !== '0) begin
      failures++; $display("FAIL mid_reset_outputs got=%b%h%h%b%b%b%b%h%h exp=0", bus.plc_error_found, bus.addr_out,
                           bus.way_out, bus.read_enable_out, bus.alt_mx_sel_out, bus.list_full, bus.check_busy,
                           bus.error_addr, bus.error_way);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({bus.plc_error_found, bus.read_enable_out, bus.check_busy, bus.list_full} !== 4'b0000) begin
        failures++; $display("FAIL post_reset%0d got=%b%b%b%b exp=0000", i, bus.plc_error_found,
                             bus.read_enable_out, bus.check_busy, bus.list_full);
      end
    end
`ifdef PLC_ERR_COUNT_EN
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL post_reset_err_count got=%0d exp=0", err_count); end
`endif
    drive_idle();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_register();
    test_check_match();
    test_check_mismatch();
    test_busy_upstream();
    test_list_full();
    test_back_to_back();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/plc_multi_checker.md
Name: plc_multi_checker

Overview:
- Parametrised successor to the single-entry PLC (protected line check) block on the L2/L1 data-array access path.
- Holds a watch list of up to LIST_DEPTH protected (addr, way) lines, each with a golden data word.
- Any later write to a watched line schedules a check-read. The read is injected into the array port on an idle cycle, the returned data is compared against golden, and a mismatch is reported.
- Outside injection cycles the array request is passed through, registered.

Parameters:
ADDR_WIDTH, 8, line index width
WAY_WIDTH, 4, way select width
DATA_SIZE, 64, data word width
LIST_DEPTH, 8, watch-list entries (power of two, >=2)
CHECK_LATENCY, 2, cycles from injected read_enable_out to valid data (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
add_to_list  in  1  arm registration of next write
addr_in  in  ADDR_WIDTH  request line index
way_in  in  WAY_WIDTH  request way
read_enable_in  in  1  upstream read request
alt_mx_sel_in  in  1  upstream alt mux select
write_enable  in  1  write strobe for addr_in/way_in
data  in  DATA_SIZE  write data, and array read data during check
plc_error_found  out  1  one-cycle mismatch pulse
addr_out  out  ADDR_WIDTH  array line index
way_out  out  WAY_WIDTH  array way
read_enable_out  out  1  array read request
alt_mx_sel_out  out  1  array alt mux select
list_full  out  1  all entries valid
check_busy  out  1  FSM not IDLE or any pending bit set
error_addr  out  ADDR_WIDTH  line of last mismatch
error_way  out  WAY_WIDTH  way of last mismatch

Behaviour:
- Reset: every output 0, all entries invalid, pending bits 0, armed 0, FSM IDLE.
- Registration:
  - add_to_list sets armed; a simultaneous write_enable does not register.
  - The first subsequent write_enable with armed=1 registers and clears armed.
  - Hit on an existing valid (addr, way): golden updated, no check scheduled.
  - Miss: allocate lowest-index free entry {valid, addr, way, golden=data}.
  - Miss with list_full: registration dropped, armed cleared.
- Watch hit: write_enable with armed=0 that matches a valid entry sets that entry's pending bit. Golden is unchanged. Duplicate hits while pending are merged.
- Passthrough: addr/way/read_enable/alt_mx_sel outputs equal the inputs delayed one cycle, except on injection cycles.
- FSM states IDLE, WAIT, REPORT.
  - IDLE → WAIT when any pending bit is set and read_enable_in=0 in cycle T.
    - Lowest pending index is selected.
    - In cycle T+1: addr_out/way_out = entry, read_enable_out=1, alt_mx_sel_out=1.
    - Upstream request in cycle T is not presented; it is write-only by the idle rule.
  - WAIT counts CHECK_LATENCY cycles. data is sampled at the end of cycle T+1+CHECK_LATENCY, then → REPORT.
  - REPORT, one cycle (T+2+CHECK_LATENCY):
    - clear pending[idx];
    - if sampled data != golden: plc_error_found=1, error_addr/error_way loaded;
    - → IDLE.
  - A watch-hit write to the entry under check during WAIT/REPORT sets pending again after clear; the entry is rechecked.
- Reset mid-check aborts immediately. No report is produced.

Optional Feature:
- PLC_ERR_COUNT_EN defined: adds output err_count, 8 bits, reset 0. It increments on each plc_error_found and saturates at 255.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package plc_pkg: FSM state enum, entry struct {valid, addr, way, golden}, default parameter constants.
- Sub-module plc_watch_list: entry storage, CAM match, free/pending priority encoders. It exposes hit index, free index, and lowest-pending index.

Test Plan:
- Register addr 8'h12 / way 4'hC / data 0 (add_to_list, then write) → entry 0 valid, no check, plc_error_found stays 0.
- Watch-hit write to 8'h55/4'hF, then data held 0 matching golden → read_enable_out=1 with addr_out=8'h55 one cycle later; no error pulse; check_busy falls after REPORT.
- Same as above but data=2 at sample cycle (T+1+CHECK_LATENCY) → plc_error_found pulses 1 cycle; error_addr=8'h55, error_way=4'hF.
- read_enable_in held 1 for 10 cycles with a pending check → no injection; passthrough continues; injection begins one cycle after read_enable_in drops.
- Register LIST_DEPTH+1 distinct lines → list_full=1 after the 8th; the 9th is ignored and not watched.
- Two writes to the same watched line in WAIT, plus rst_n asserted mid-WAIT in a second run → exactly one recheck; after reset all outputs are 0 and no pulse occurs.
